// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler
// Shares one pump and valve manifold among NZONES greenhouse zones. Pending
// zone requests are arbitrated with urgent requests first and round-robin
// inside each class. The granted zone is then sequenced through valve open,
// settle, pump run, pump stop, valve close and cooldown. A low tank or an
// operator stop aborts an active watering cleanly. A low tank also latches a
// sticky fault that blocks further grants until it is cleared.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   zone_req     per-zone level irrigation request
//   zone_urgent  per-zone urgent qualifier (only meaningful with zone_req)
//   tank_low     water tank below minimum level
//   manual_stop  operator stop, level sensitive
//   fault_clr    single-cycle pulse clearing the fault flag
//   pump_on      pump drive
//   valve_sel    one-hot valve drive, zero when no zone is being watered
//   active_zone  index of the granted zone, holds its value while idle
//   busy         high whenever a watering sequence is in progress
//   grant_pulse  one cycle, first cycle of valve opening
//   done_pulse   one cycle, first cycle of cooldown
//   fault        sticky tank-low abort flag
module irrigation_zone_scheduler #(
    parameter int NZONES          = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int RUN_CYCLES      = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NZONES-1:0]         zone_req,
    input  logic [NZONES-1:0]         zone_urgent,
    input  logic                      tank_low,
    input  logic                      manual_stop,
    input  logic                      fault_clr,
    output logic                      pump_on,
    output logic [NZONES-1:0]         valve_sel,
    output logic [$clog2(NZONES)-1:0] active_zone,
    output logic                      busy,
    output logic                      grant_pulse,
    output logic                      done_pulse,
    output logic                      fault
);

    localparam int ZW      = $clog2(NZONES);
    localparam int MAX_SR  = (SETTLE_CYCLES > RUN_CYCLES) ? SETTLE_CYCLES : RUN_CYCLES;
    localparam int MAX_ALL = (MAX_SR > COOLDOWN_CYCLES) ? MAX_SR : COOLDOWN_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST    = CW'(RUN_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [ZW-1:0] LAST_ZONE   = ZW'(NZONES - 1);

    typedef enum logic [2:0] {IDLE, OPEN, RUN, CLOSE, COOLDOWN} state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [ZW-1:0]     rr_ptr;

    logic [NZONES-1:0] eligible;
    logic [NZONES-1:0] urgent_elig;
    logic [NZONES-1:0] candidates;
    logic [ZW-1:0]     winner;
    int                idx;

    logic              abort;
    logic              grant;
    logic              done;
    logic              next_fault;
    logic [ZW-1:0]     next_zone;
    logic [NZONES-1:0] next_valve;

    // Arbitration: urgent eligible zones shadow ordinary ones. The search
    // walks offsets downward so the last hit is the one closest to rr_ptr,
    // which gives "first at or after rr_ptr, wrapping" without a priority
    // encoder per rotation.
    always_comb begin
        eligible = '0;
        if (!tank_low && !manual_stop && !fault) begin
            eligible = zone_req;
        end
        urgent_elig = eligible & zone_urgent;
        candidates  = (|urgent_elig) ? urgent_elig : eligible;
        winner      = '0;
        idx         = 0;
        for (int i = NZONES - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NZONES) begin
                idx = idx - NZONES;
            end
            if (candidates[idx]) begin
                winner = idx[ZW-1:0];
            end
        end
    end

    // Sequencer next state plus the one-cycle pulse conditions. Abort is
    // only honoured in OPEN and RUN; once the pump has stopped the close and
    // cooldown always run to completion so the valve never closes early.
    always_comb begin
        abort      = tank_low || manual_stop;
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    next_state = OPEN;
                    grant      = 1'b1;
                end
            end
            OPEN: begin
                if (abort) begin
                    next_state = CLOSE;
                end else if (cnt == SETTLE_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort || !zone_req[active_zone] || cnt == RUN_LAST) begin
                    next_state = CLOSE;
                end
            end
            CLOSE: begin
                if (cnt == SETTLE_LAST) begin
                    next_state = COOLDOWN;
                    done       = 1'b1;
                end
            end
            COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs. Setting the fault takes
    // priority over clearing it, and a clear is refused while the tank is
    // still low.
    always_comb begin
        next_fault = fault;
        if ((state == OPEN || state == RUN) && tank_low) begin
            next_fault = 1'b1;
        end else if (fault_clr && !tank_low) begin
            next_fault = 1'b0;
        end
        next_zone  = grant ? winner : active_zone;
        next_valve = '0;
        if (next_state == OPEN || next_state == RUN || next_state == CLOSE) begin
            next_valve[next_zone] = 1'b1;
        end
    end

    // State, counter, round-robin pointer and registered outputs. Reset
    // drops the pump and valves immediately with no close sequence. The
    // counter restarts on every state change and idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            pump_on     <= 1'b0;
            valve_sel   <= '0;
            active_zone <= '0;
            busy        <= 1'b0;
            grant_pulse <= 1'b0;
            done_pulse  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (grant) begin
                rr_ptr <= (winner == LAST_ZONE) ? '0 : winner + ZW'(1);
            end
            pump_on     <= (next_state == RUN);
            valve_sel   <= next_valve;
            active_zone <= next_zone;
            busy        <= (next_state != IDLE);
            grant_pulse <= grant;
            done_pulse  <= done;
            fault       <= next_fault;
        end
    end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler
// Directed bench for irrigation_zone_scheduler at default parameters.
// Cycle numbers in the comments below count samples after a grant: r=1 is
// the first OPEN cycle (grant_pulse high).
module tb_irrigation_zone_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] zone_req;
    logic [3:0] zone_urgent;
    logic       tank_low;
    logic       manual_stop;
    logic       fault_clr;
    logic       pump_on;
    logic [3:0] valve_sel;
    logic [1:0] active_zone;
    logic       busy;
    logic       grant_pulse;
    logic       done_pulse;
    logic       fault;

    int checks;
    int errors;
    int pumpCycles;

    irrigation_zone_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .zone_req    (zone_req),
        .zone_urgent (zone_urgent),
        .tank_low    (tank_low),
        .manual_stop (manual_stop),
        .fault_clr   (fault_clr),
        .pump_on     (pump_on),
        .valve_sel   (valve_sel),
        .active_zone (active_zone),
        .busy        (busy),
        .grant_pulse (grant_pulse),
        .done_pulse  (done_pulse),
        .fault       (fault)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Drives all control inputs in one go.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] urg,
                                 input logic tl, input logic ms, input logic fc);
        zone_req    = req;
        zone_urgent = urg;
        tank_low    = tl;
        manual_stop = ms;
        fault_clr   = fc;
    endtask

    // Advances one clock and samples 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pump_on) pumpCycles++;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Waits for the next grant_pulse, bounded to 100 cycles.
    task automatic waitGrant(input string tag, output logic [1:0] zone, output int waited);
        waited = 0;
        zone   = '0;
        while (1) begin
            step();
            waited++;
            if (grant_pulse) begin
                zone = active_zone;
                break;
            end
            if (waited >= 100) begin
                checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] z;
        int         w;
        int         grantsSeen;

        checks = 0;
        errors = 0;
        pumpCycles = 0;
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset state
        #2;
        checkOutput("rst_pump", pump_on, 0);
        checkOutput("rst_valve", valve_sel, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant", grant_pulse, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_zone", active_zone, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single zone, full sequence and immediate re-grant
        $display("[TB] single zone sequence");
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t1_grant", z, w);
        checkOutput("t1_latency", w, 1);
        checkOutput("t1_zone", z, 1);
        checkOutput("t1_valve_open", valve_sel, 4'b0010);
        checkOutput("t1_busy", busy, 1);
        pumpCycles = 0;
        for (int r = 2; r <= 30; r++) begin
            step();
            if (r == 2)  checkOutput("t1_open_pump", pump_on, 0);
            if (r == 3)  checkOutput("t1_run_start", pump_on, 1);
            if (r == 18) checkOutput("t1_run_end", pump_on, 1);
            if (r == 19) checkOutput("t1_close_pump", pump_on, 0);
            if (r == 20) checkOutput("t1_close_valve", valve_sel, 4'b0010);
            if (r == 21) checkOutput("t1_cool_valve", valve_sel, 0);
            if (r == 21) checkOutput("t1_done", done_pulse, 1);
            if (r == 22) checkOutput("t1_done_once", done_pulse, 0);
            if (r == 28) checkOutput("t1_cool_busy", busy, 1);
            if (r == 29) checkOutput("t1_idle_busy", busy, 0);
            if (r == 30) checkOutput("t1_regrant", grant_pulse, 1);
            if (r == 30) checkOutput("t1_regrant_zone", active_zone, 1);
        end
        checkOutput("t1_pump_total", pumpCycles, 16);

        // 2: all zones requesting, plain round-robin
        $display("[TB] round robin");
        resetDut();
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t2_g0", z, w);
        checkOutput("t2_g0_zone", z, 0);
        for (int g = 1; g <= 4; g++) begin
            waitGrant("t2_g", z, w);
            checkOutput("t2_zone", z, g % 4);
            checkOutput("t2_spacing", w, 29);
        end

        // 3: urgent request overtakes round-robin order
        $display("[TB] urgent priority");
        resetDut();
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t3_g0", z, w);
        checkOutput("t3_g0_zone", z, 0);
        stepN(4);
        checkOutput("t3_in_run", pump_on, 1);
        applyStimulus(4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0);
        waitGrant("t3_g1", z, w);
        checkOutput("t3_urgent_zone", z, 3);
        checkOutput("t3_urgent_wait", w, 25);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t3_g2", z, w);
        checkOutput("t3_wrap_zone", z, 0);

        // 4: granted zone drops its request during RUN
        $display("[TB] request drop");
        resetDut();
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t4_grant", z, w);
        checkOutput("t4_zone", z, 2);
        pumpCycles = 0;
        stepN(6);
        checkOutput("t4_run5_pump", pump_on, 1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t4_drop_pump", pump_on, 0);
        checkOutput("t4_drop_valve", valve_sel, 4'b0100);
        step();
        checkOutput("t4_close2_valve", valve_sel, 4'b0100);
        step();
        checkOutput("t4_closed_valve", valve_sel, 0);
        checkOutput("t4_done", done_pulse, 1);
        checkOutput("t4_pump_total", pumpCycles, 5);

        // 5: tank-low abort, sticky fault and clearing rules
        $display("[TB] tank low fault");
        resetDut();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t5_grant", z, w);
        stepN(3);
        checkOutput("t5_in_run", pump_on, 1);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t5_abort_pump", pump_on, 0);
        checkOutput("t5_fault_set", fault, 1);
        checkOutput("t5_abort_valve", valve_sel, 4'b0001);
        stepN(2);
        checkOutput("t5_done", done_pulse, 1);
        checkOutput("t5_cool_valve", valve_sel, 0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        grantsSeen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant_pulse) grantsSeen++;
        end
        checkOutput("t5_blocked_grants", grantsSeen, 0);
        checkOutput("t5_fault_held", fault, 1);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput("t5_clr_ignored", fault, 1);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("t5_clr_done", fault, 0);
        checkOutput("t5_no_grant_yet", grant_pulse, 0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t5_regrant", grant_pulse, 1);
        checkOutput("t5_regrant_zone", active_zone, 0);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput("t5_set_wins", fault, 1);
        checkOutput("t5_open_abort_busy", busy, 1);

        // Manual stop during OPEN: pump never starts, no fault
        $display("[TB] manual stop");
        resetDut();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t5m_grant", z, w);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t5m_valve", valve_sel, 4'b0001);
        checkOutput("t5m_fault", fault, 0);
        step();
        checkOutput("t5m_no_run", pump_on, 0);

        // 6: asynchronous reset in the middle of RUN
        $display("[TB] async reset");
        resetDut();
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t6_grant", z, w);
        stepN(3);
        checkOutput("t6_in_run", pump_on, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_pump", pump_on, 0);
        checkOutput("t6_valve", valve_sel, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_fault", fault, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        waitGrant("t6_regrant", z, w);
        checkOutput("t6_restart_zone", z, 0);
        checkOutput("t6_restart_latency", w, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
